// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer preset path.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [23:0] TIMER_DIGIT_MAX    = 24'h595999;
    localparam int          TIMER_REPEAT_DELAY = 50_000_000;
    localparam int          TIMER_REPEAT_RATE  = 10_000_000;

endpackage

// File: rtl/button_press_gen.sv
// Active-low button conditioning: 2-flop synchroniser, history flop for
// press detection, and a hold-to-repeat counter.
module button_press_gen #(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic hold_ok,
    output logic held,
    output logic press,
    output logic rpt
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam bit RPT_ON = REPEAT_EN && (REPEAT_DELAY != 0);

    logic          sync_a;
    logic          sync_b;
    logic          hist;
    logic [CW-1:0] cnt;
    logic          rate_phase;

    assign held  = ~sync_b;
    assign press = hist & ~sync_b;

    // cnt holds cycles since the last press or repeat; zero means idle.
    always_comb begin
        rpt = 1'b0;
        if (RPT_ON && held && hold_ok && (cnt != '0))
            rpt = rate_phase ? (cnt == RATE_C) : (cnt == DELAY_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a     <= 1'b1;
            sync_b     <= 1'b1;
            hist       <= 1'b1;
            cnt        <= '0;
            rate_phase <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            hist   <= sync_b;
            if (!RPT_ON || !held || !hold_ok) begin
                cnt        <= '0;
                rate_phase <= 1'b0;
            end else if (press) begin
                cnt        <= ONE_C;
                rate_phase <= 1'b0;
            end else if (rpt) begin
                cnt        <= ONE_C;
                rate_phase <= 1'b1;
            end else if (cnt != '0) begin
                cnt <= cnt + ONE_C;
            end
        end
    end

endmodule

// File: rtl/bcd_field_editor.sv
// Multi-digit BCD preset editor: cursor, inc/dec with optional ripple
// carry/borrow, hold-to-repeat, clamped parallel load and edit enable.
module bcd_field_editor
    import timer_pkg::*;
#(
    parameter int                    N_DIGITS     = 6,
    parameter logic [4*N_DIGITS-1:0] DIGIT_MAX    = (4*N_DIGITS)'(TIMER_DIGIT_MAX),
    parameter int                    REPEAT_DELAY = TIMER_REPEAT_DELAY,
    parameter int                    REPEAT_RATE  = TIMER_REPEAT_RATE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sel,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    carry_mode,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   load_val,
    output logic [N_DIGITS-1:0]     digit_sel,
    output logic [4*N_DIGITS-1:0]   digits,
    output logic                    changed
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IW-1:0] MSD   = IW'(N_DIGITS - 1);
    localparam logic [IW-1:0] ONE_I = IW'(1);

    logic                  sel_press, inc_press, dec_press;
    logic                  inc_held, dec_held, inc_rpt, dec_rpt;
    logic                  sel_held_unused, sel_rpt_unused;
    logic                  hold_ok, inc_step, dec_step, sel_step;
    logic [IW-1:0]         cur_q;
    logic [4*N_DIGITS-1:0] digits_q, step_val, load_clamp;
    logic                  ripple;
    bcd_t                  cur_d, max_d, new_d, ld_d;

    // Holding both step buttons suppresses repeats on both.
    assign hold_ok  = en & ~(inc_held & dec_held);
    assign inc_step = en & (inc_press | inc_rpt);
    assign dec_step = en & (dec_press | dec_rpt);
    assign sel_step = en & sel_press;

    button_press_gen #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0)
    ) u_sel (
        .clk(clk), .rst(rst), .btn(sel), .hold_ok(1'b0),
        .held(sel_held_unused), .press(sel_press), .rpt(sel_rpt_unused)
    );

    button_press_gen #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
    ) u_inc (
        .clk(clk), .rst(rst), .btn(inc), .hold_ok(hold_ok),
        .held(inc_held), .press(inc_press), .rpt(inc_rpt)
    );

    button_press_gen #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
    ) u_dec (
        .clk(clk), .rst(rst), .btn(dec), .hold_ok(hold_ok),
        .held(dec_held), .press(dec_press), .rpt(dec_rpt)
    );

    // The ripple starts at the cursor and only propagates past a digit that
    // wrapped, and only in carry mode.
    always_comb begin
        step_val = digits_q;
        ripple   = 1'b0;
        cur_d    = '0;
        max_d    = '0;
        new_d    = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            cur_d = digits_q[4*i +: 4];
            max_d = DIGIT_MAX[4*i +: 4];
            new_d = cur_d;
            if (cur_q == IW'(i))
                ripple = 1'b1;
            if (ripple) begin
                if (inc_step) begin
                    if (cur_d >= max_d) begin
                        new_d  = '0;
                        ripple = carry_mode;
                    end else begin
                        new_d  = cur_d + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (cur_d == '0) begin
                        new_d  = max_d;
                        ripple = carry_mode;
                    end else begin
                        new_d  = cur_d - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
            step_val[4*i +: 4] = new_d;
        end
    end

    always_comb begin
        load_clamp = '0;
        ld_d       = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            ld_d = load_val[4*i +: 4];
            load_clamp[4*i +: 4] = (ld_d > DIGIT_MAX[4*i +: 4]) ? DIGIT_MAX[4*i +: 4] : ld_d;
        end
    end

    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < N_DIGITS; i++)
            digit_sel[i] = (cur_q == IW'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits_q <= '0;
            cur_q    <= MSD;
            changed  <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (load) begin
                digits_q <= load_clamp;
                changed  <= 1'b1;
            end else begin
                if (inc_step ^ dec_step) begin
                    digits_q <= step_val;
                    changed  <= 1'b1;
                end
                if (sel_step)
                    cur_q <= (cur_q == '0) ? MSD : cur_q - ONE_I;
            end
        end
    end

    assign digits = digits_q;

endmodule

// File: doc/bcd_field_editor.md
# bcd_field_editor

Parametrised BCD field editor for the timer's preset path. It holds N_DIGITS BCD digits, each with its own per-digit maximum. Three active-low buttons drive it: sel moves the cursor, inc and dec step the selected digit. Beyond single-step editing it adds hold-to-repeat, an optional carry/borrow mode across digits, a parallel load from the running counter, and an edit-enable gate. Its outputs feed the countdown preset and the display blinker (digit_sel).

## Interface
- N_DIGITS, 6: digit count, 1..8.
- DIGIT_MAX, 24'h595999: packed 4·N_DIGITS bits; nibble i is the max of digit i (each ≤ 9).
- REPEAT_DELAY, 50_000_000: cycles a step button must be held before the first repeat; 0 disables repeat.
- REPEAT_RATE, 10_000_000: cycles between subsequent repeats; ≥ 1.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  edit enable; when 0, buttons are ignored.
- sel  in  1  cursor button, asynchronous, active-low (a press is a falling edge).
- inc  in  1  increment button, asynchronous, active-low.
- dec  in  1  decrement button, asynchronous, active-low.
- carry_mode  in  1  1 selects ripple carry/borrow; 0 selects per-digit wrap.
- load  in  1  synchronous parallel-load strobe.
- load_val  in  4·N_DIGITS  load value; nibble i is digit i.
- digit_sel  out  N_DIGITS  one-hot cursor position.
- digits  out  4·N_DIGITS  field value; nibble i is digit i, i=0 is least significant.
- changed  out  1  one-cycle pulse, registered with digits, whenever digits is written.

## Operation
- **Reset:** digits=0, digit_sel=1<<(N_DIGITS−1) (cursor on the MSD), changed=0, repeat counters=0, synchroniser flops=1 (buttons released).
- **Button conditioning:** each button passes through a 2-flop synchroniser plus a history flop. A press pulse fires when the history flop is 1 and the synchronised value is 0.
- **sel press (en=1):** the cursor moves one digit lower, i→i−1. From digit 0 it wraps to N_DIGITS−1.
- **inc step, carry_mode=0:** digit i goes to 0 if at DIGIT_MAX[i], otherwise +1. No other digit changes.
- **dec step, carry_mode=0:** digit i goes to DIGIT_MAX[i] if at 0, otherwise −1. No other digit changes.
- **inc step, carry_mode=1:** when a digit wraps, the carry ripples into digit i+1, and so on upward. If every digit from i upward is at its max, all of them become 0 and there is no overflow flag.
- **dec step, carry_mode=1:** borrow ripples upward the same way. If every digit from i upward is 0, all of them become their max.
- **Auto-repeat:** while inc alone (synchronised) stays low, the first repeat step fires REPEAT_DELAY cycles after the press pulse, then one step every REPEAT_RATE cycles. dec behaves the same. If both are held, no repeats occur and the counter clears. Releasing either button clears the counter.
- **Priority, highest first:**
  1. load: digit i takes min(load_val nibble i, DIGIT_MAX[i]). Steps in that cycle are dropped; the cursor is unchanged.
  2. inc and dec in the same cycle: no change.
  3. inc or dec step.
- **sel together with inc/dec in the same cycle:** the step applies to the old cursor position; the cursor moves on the same edge.
- **en=0:** press pulses and repeats are ignored and the repeat counters stay at 0. load still applies. Synchroniser flops keep running, so raising en never creates a press.
- **changed:** high for exactly one cycle after any edge that applied a load or a step.

## Timing
- Button low first sampled at edge n. The press pulse is high between edges n+1 and n+2. digits, digit_sel and changed update at edge n+2.
- load sampled high at edge n: digits and changed update at edge n. Latency is 0 extra cycles.
- Repeat step k≥1 updates digits at edge n+2+REPEAT_DELAY+(k−1)·REPEAT_RATE.
- Reset is asserted asynchronously and released synchronously by the system reset bridge. The block has no internal reset synchroniser.
- Counter width is $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1). The cursor index width is max(1,$clog2(N_DIGITS)).

## Structure
- Package timer_pkg holds:
  - typedef bcd_t (logic [3:0]),
  - constant TIMER_DIGIT_MAX = 24'h595999,
  - default repeat constants.
- Sub-module button_press_gen provides the synchroniser, press detect and repeat counter.
  - Parameters: REPEAT_DELAY, REPEAT_RATE, REPEAT_EN.
  - Instantiated three times; sel uses REPEAT_EN=0.
  - The both-held inhibit lives in the top level.
- The carry/borrow ripple is an always_comb loop over N_DIGITS in the top level.

## Test plan
- **Reset and cursor wrap:** reset, then 6 sel presses → digit_sel goes 100000→010000→…→000001→100000; digits stay 0; changed stays 0.
- **Per-digit wrap (carry_mode=0):** cursor on digit 5, dec press → digit 5 = 5. Cursor on digit 2: 10 inc presses → digit 2 returns to 0, all other digits unchanged.
- **Carry ripple (carry_mode=1):** load 24'h000999, cursor on digit 0, inc → 24'h001000. Load 24'h595999, inc → 24'h000000. From 0, dec → 24'h595999.
- **Auto-repeat (REPEAT_DELAY=8, REPEAT_RATE=4):** hold inc 30 cycles on digit 0 → steps at press+2, +10, +14, +18, +22, +26, +30. Holding inc and dec together → single steps only, which cancel.
- **Load clamp and priority:** load_val=24'h9F9999 with an inc press in the same cycle → digits=24'h595999, changed=1 for one cycle, inc dropped.
- **en=0 and mid-operation reset:** en=0 → presses ignored but load works. Asserting rst during a held inc → all outputs return to reset values immediately, and no step occurs after release.
